// File: rtl/control_sequencer_if.sv
// Control-unit bus: opcode and flags in from the IR/flags registers, control word and
// sequencing status out to the datapath.
interface control_sequencer_if;
    logic [3:0]  opcode;
    logic        cf;
    logic        zf;
    logic [15:0] cw;
    logic [2:0]  step;
    logic        halted;

    // Sequencer side.
    modport master (
        input  opcode,
        input  cf,
        input  zf,
        output cw,
        output step,
        output halted
    );

    // Datapath side.
    modport slave (
        output opcode,
        output cf,
        output zf,
        input  cw,
        input  step,
        input  halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcode control unit: walks each instruction through T-states T0..T4 and drives the
// datapath control word from the current step, opcode and flags.
module control_sequencer #(
    parameter int unsigned FAST_FETCH = 0,
    parameter int unsigned INI        = 0
) (
    input  logic                  clk,
    input  logic                  clrbar,
    control_sequencer_if.master   bus
);

    // Control word bit positions.
    localparam logic [15:0] CwHlt = 16'h8000;
    localparam logic [15:0] CwMi  = 16'h4000;
    localparam logic [15:0] CwRi  = 16'h2000;
    localparam logic [15:0] CwRo  = 16'h1000;
    localparam logic [15:0] CwIo  = 16'h0800;
    localparam logic [15:0] CwIi  = 16'h0400;
    localparam logic [15:0] CwAi  = 16'h0200;
    localparam logic [15:0] CwAo  = 16'h0100;
    localparam logic [15:0] CwEo  = 16'h0080;
    localparam logic [15:0] CwSu  = 16'h0040;
    localparam logic [15:0] CwBi  = 16'h0020;
    localparam logic [15:0] CwOi  = 16'h0010;
    localparam logic [15:0] CwCe  = 16'h0008;
    localparam logic [15:0] CwCo  = 16'h0004;
    localparam logic [15:0] CwJ   = 16'h0002;
    localparam logic [15:0] CwFi  = 16'h0001;

    localparam logic [3:0] OpNop = 4'b0000;
    localparam logic [3:0] OpLda = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0011;
    localparam logic [3:0] OpSta = 4'b0100;
    localparam logic [3:0] OpLdi = 4'b0101;
    localparam logic [3:0] OpJmp = 4'b0110;
    localparam logic [3:0] OpJc  = 4'b0111;
    localparam logic [3:0] OpJz  = 4'b1000;
    localparam logic [3:0] OpOut = 4'b1110;
    localparam logic [3:0] OpHlt = 4'b1111;

    localparam logic [2:0] StepIni = 3'(INI);

    logic [2:0] step_q, step_d;
    logic       halted_q, halted_d;
    logic [2:0] last_step;
    logic [15:0] cw;

    // State register: step counter and halt latch, synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clrbar) begin
            step_q   <= StepIni;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Next state: advance or wrap to T0, freeze once halted.
    always_comb begin
        last_step = 3'd4;
        if (FAST_FETCH != 0) begin
            unique case (bus.opcode)
                OpLda, OpSta: last_step = 3'd3;
                OpAdd, OpSub: last_step = 3'd4;
                default:      last_step = 3'd2;
            endcase
        end

        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (bus.opcode == OpHlt && step_q == 3'd2) begin
                // Step stays at T2 so the halted state shows where it stopped.
                halted_d = 1'b1;
            end else if (step_q >= last_step) begin
                step_d = 3'd0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    // Output decode: control word for the current microstep.
    always_comb begin
        cw = 16'h0000;
        if (!clrbar) begin
            cw = 16'h0000;
        end else if (halted_q) begin
            cw = CwHlt;
        end else begin
            case (step_q)
                3'd0: cw = CwCo | CwMi;
                3'd1: cw = CwRo | CwIi | CwCe;
                3'd2: begin
                    case (bus.opcode)
                        OpLda, OpAdd, OpSub: cw = CwIo | CwMi;
                        OpSta:               cw = CwIo | CwMi;
                        OpLdi:               cw = CwIo | CwAi;
                        OpJmp:               cw = CwIo | CwJ;
                        // Flags only matter here; conditional jumps fall through as NOP.
                        OpJc:                cw = bus.cf ? (CwIo | CwJ) : 16'h0000;
                        OpJz:                cw = bus.zf ? (CwIo | CwJ) : 16'h0000;
                        OpOut:               cw = CwAo | CwOi;
                        OpHlt:               cw = CwHlt;
                        OpNop:               cw = 16'h0000;
                        default:             cw = 16'h0000;
                    endcase
                end
                3'd3: begin
                    case (bus.opcode)
                        OpLda:        cw = CwRo | CwAi;
                        OpAdd, OpSub: cw = CwRo | CwBi;
                        OpSta:        cw = CwAo | CwRi;
                        default:      cw = 16'h0000;
                    endcase
                end
                3'd4: begin
                    case (bus.opcode)
                        OpAdd:   cw = CwEo | CwAi | CwFi;
                        OpSub:   cw = CwEo | CwSu | CwAi | CwFi;
                        default: cw = 16'h0000;
                    endcase
                end
                default: cw = 16'h0000;
            endcase
        end
    end

    assign bus.cw     = cw;
    assign bus.step   = step_q;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: three instances (plain, fast fetch, fast fetch with INI=4)
// share stimulus and are compared every cycle against a microprogram-table model.
module tb_control_sequencer;

    localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000;
    localparam logic [15:0] B_RO  = 16'h1000, B_IO = 16'h0800, B_II = 16'h0400;
    localparam logic [15:0] B_AI  = 16'h0200, B_AO = 16'h0100, B_EO = 16'h0080;
    localparam logic [15:0] B_SU  = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010;
    localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002;
    localparam logic [15:0] B_FI  = 16'h0001;

    logic       clk = 1'b0;
    logic       clrbar;
    logic [3:0] opcode;
    logic       cf, zf;

    always #5 clk = ~clk;

    control_sequencer_if bus0 ();
    control_sequencer_if bus1 ();
    control_sequencer_if bus2 ();

    assign bus0.opcode = opcode;
    assign bus0.cf     = cf;
    assign bus0.zf     = zf;
    assign bus1.opcode = opcode;
    assign bus1.cf     = cf;
    assign bus1.zf     = zf;
    assign bus2.opcode = opcode;
    assign bus2.cf     = cf;
    assign bus2.zf     = zf;

    control_sequencer #(.FAST_FETCH(0), .INI(0)) u0 (.clk(clk), .clrbar(clrbar), .bus(bus0));
    control_sequencer #(.FAST_FETCH(1), .INI(0)) u1 (.clk(clk), .clrbar(clrbar), .bus(bus1));
    control_sequencer #(.FAST_FETCH(1), .INI(4)) u2 (.clk(clk), .clrbar(clrbar), .bus(bus2));

    logic [15:0] cw_a [3];
    logic [2:0]  step_a [3];
    logic        halted_a [3];

    assign cw_a[0] = bus0.cw;
    assign cw_a[1] = bus1.cw;
    assign cw_a[2] = bus2.cw;
    assign step_a[0] = bus0.step;
    assign step_a[1] = bus1.step;
    assign step_a[2] = bus2.step;
    assign halted_a[0] = bus0.halted;
    assign halted_a[1] = bus1.halted;
    assign halted_a[2] = bus2.halted;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: microprogram table plus per-opcode instruction length.
    logic [15:0] ucode [16][5];
    int          last_tbl [16];
    int          ff_a [3]  = '{0, 1, 1};
    int          ini_a [3] = '{0, 0, 4};
    int          m_step [3];
    bit          m_halted [3];
    bit          m_valid = 1'b0;

    initial begin
        for (int op = 0; op < 16; op++) begin
            ucode[op][0] = B_CO | B_MI;
            ucode[op][1] = B_RO | B_II | B_CE;
            ucode[op][2] = 16'h0000;
            ucode[op][3] = 16'h0000;
            ucode[op][4] = 16'h0000;
            last_tbl[op] = 2;
        end
        ucode[1][2]  = B_IO | B_MI;  ucode[1][3] = B_RO | B_AI;  last_tbl[1] = 3;
        ucode[2][2]  = B_IO | B_MI;  ucode[2][3] = B_RO | B_BI;
        ucode[2][4]  = B_EO | B_AI | B_FI;  last_tbl[2] = 4;
        ucode[3][2]  = B_IO | B_MI;  ucode[3][3] = B_RO | B_BI;
        ucode[3][4]  = B_EO | B_SU | B_AI | B_FI;  last_tbl[3] = 4;
        ucode[4][2]  = B_IO | B_MI;  ucode[4][3] = B_AO | B_RI;  last_tbl[4] = 3;
        ucode[5][2]  = B_IO | B_AI;
        ucode[6][2]  = B_IO | B_J;
        ucode[7][2]  = B_IO | B_J;
        ucode[8][2]  = B_IO | B_J;
        ucode[14][2] = B_AO | B_OI;
        ucode[15][2] = B_HLT;
    end

    function automatic logic [15:0] exp_cw(input int k);
        logic [15:0] w;
        if (!clrbar) return 16'h0000;
        if (m_halted[k]) return B_HLT;
        w = ucode[opcode][m_step[k]];
        if (m_step[k] == 2 && ((opcode == 4'd7 && !cf) || (opcode == 4'd8 && !zf))) w = 16'h0000;
        return w;
    endfunction

    // Model state update on each rising edge.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!clrbar) begin
                m_step[k]   = ini_a[k];
                m_halted[k] = 1'b0;
            end else if (!m_halted[k]) begin
                if (opcode == 4'd15 && m_step[k] == 2) begin
                    m_halted[k] = 1'b1;
                end else if (m_step[k] >= ((ff_a[k] != 0) ? last_tbl[opcode] : 4)) begin
                    m_step[k] = 0;
                end else begin
                    m_step[k] = m_step[k] + 1;
                end
            end
        end
        m_valid = 1'b1;
    end

    // Compare every instance against the model mid-cycle, plus structural invariants.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("u%0d cw", k), 32'(cw_a[k]), 32'(exp_cw(k)));
                check($sformatf("u%0d step", k), 32'(step_a[k]), 32'(m_step[k]));
                check($sformatf("u%0d halted", k), 32'(halted_a[k]), 32'(m_halted[k]));
                check($sformatf("u%0d ce_and_j", k), 32'(cw_a[k][3] & cw_a[k][1]), 32'd0);
                check($sformatf("u%0d bus_drivers_le1", k),
                      32'($countones({cw_a[k][2], cw_a[k][12], cw_a[k][11],
                                      cw_a[k][8], cw_a[k][7]}) <= 1), 32'd1);
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clrbar = 1'b0;
        adv();
        clrbar = 1'b1;
    endtask

    logic [15:0] add_seq [5] = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281};

    initial begin
        clrbar = 1'b0;
        opcode = 4'b0010;
        cf     = 1'b0;
        zf     = 1'b0;
        adv();
        adv();
        @(negedge clk);
        check("reset cw forced 0", 32'(bus0.cw), 32'h0000);
        adv();
        clrbar = 1'b1;

        // ADD, plain fetch: literal control words per step.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("add T%0d cw", i), 32'(bus0.cw), 32'(add_seq[i]));
            check($sformatf("add T%0d step", i), 32'(bus0.step), i);
            if (i == 0) check("reset halted", 32'(bus0.halted), 32'd0);
            adv();
        end
        @(negedge clk);
        check("add wrap step", 32'(bus0.step), 32'd0);
        check("add wrap cw", 32'(bus0.cw), 32'h4004);

        // JC not taken, then taken; fast fetch returns to T0 after T2.
        for (int t = 0; t < 2; t++) begin
            adv();
            opcode = 4'b0111;
            cf     = (t == 1);
            do_reset();
            adv();
            adv();
            @(negedge clk);
            check("jc T2 cw u0", 32'(bus0.cw), (t == 1) ? 32'h0802 : 32'h0000);
            check("jc T2 cw u1", 32'(bus1.cw), (t == 1) ? 32'h0802 : 32'h0000);
            adv();
            cf = ~cf;
            @(negedge clk);
            check("jc fast next step", 32'(bus1.step), 32'd0);
            check("jc slow next step", 32'(bus0.step), 32'd3);
            check("jc late flag cw", 32'(bus0.cw), 32'h0000);
        end

        // Halt: freeze at T2 with HLT-only control word.
        adv();
        opcode = 4'b1111;
        do_reset();
        adv();
        adv();
        @(negedge clk);
        check("hlt T2 cw", 32'(bus0.cw), 32'h8000);
        check("hlt T2 halted", 32'(bus0.halted), 32'd0);
        for (int i = 0; i < 10; i++) begin
            adv();
            opcode = 4'(i);
            @(negedge clk);
            check("halted cw", 32'(bus0.cw), 32'h8000);
            check("halted step", 32'(bus0.step), 32'd2);
            check("halted flag", 32'(bus0.halted), 32'd1);
        end
        adv();
        clrbar = 1'b0;
        @(negedge clk);
        check("halt clr cw", 32'(bus0.cw), 32'h0000);
        adv();
        clrbar = 1'b1;
        @(negedge clk);
        check("halt clr step", 32'(bus0.step), 32'd0);
        check("halt clr halted", 32'(bus0.halted), 32'd0);

        // Reset in the middle of SUB.
        adv();
        opcode = 4'b0011;
        do_reset();
        adv();
        adv();
        adv();
        clrbar = 1'b0;
        @(negedge clk);
        check("sub mid clr cw", 32'(bus0.cw), 32'h0000);
        check("sub mid clr step", 32'(bus0.step), 32'd3);
        adv();
        clrbar = 1'b1;
        @(negedge clk);
        check("sub after clr step", 32'(bus0.step), 32'd0);
        check("sub after clr cw", 32'(bus0.cw), 32'h4004);

        // Sweep all opcodes with changing flags; the compare process checks each cycle.
        for (int op = 0; op < 16; op++) begin
            adv();
            opcode = 4'(op);
            do_reset();
            for (int c = 0; c < 12; c++) begin
                cf = c[0];
                zf = c[1] ^ c[2];
                adv();
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
